// File: rtl/uart_tx_fifo_ctrl.sv
// Transmit-side byte FIFO and launch controller for a UART transmitter.
// Buffers host writes and releases one byte per tx_start / tx_done_tick exchange.
module uart_tx_fifo_ctrl #(
  parameter int DBIT   = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [DBIT-1:0]   wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              ovf_tick,
  output logic              tx_busy,
  output logic              tx_start,
  output logic [DBIT-1:0]   tx_din,
  input  logic              tx_done_tick,
  output logic              state_dbg
);

  // Handshakes: a host write is taken on any edge where wr_en=1 and the
  // registered full=0; otherwise it is dropped and ovf_tick pulses. Toward
  // the transmitter, tx_start is a one-cycle launch of tx_din, and no new
  // launch happens until tx_done_tick has been seen in BUSY.

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic [DBIT-1:0]   mem [2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              wr_accept;
  logic              pop;
  logic              tx_start_d;
  logic              tx_busy_d;
  logic [ADDR_W:0]   count_d;

  // full is the registered flag, so a pop in the same cycle cannot make room
  assign wr_accept = wr_en & ~full;
  assign count_d   = count + {{ADDR_W{1'b0}}, wr_accept} - {{ADDR_W{1'b0}}, pop};
  assign state_dbg = state_q;

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    tx_start_d = 1'b0;
    tx_busy_d  = tx_busy;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          tx_start_d = 1'b1;
          tx_busy_d  = 1'b1;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (tx_done_tick) begin
          tx_busy_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once pointers clear
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      ovf_tick <= 1'b0;
      tx_start <= 1'b0;
      tx_busy  <= 1'b0;
      tx_din   <= '0;
    end else begin
      ovf_tick <= wr_en & full;
      tx_start <= tx_start_d;
      tx_busy  <= tx_busy_d;
      count    <= count_d;
      empty    <= (count_d == '0);
      full     <= (count_d == FULL_CNT);
      if (wr_accept) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        tx_din <= mem[rd_ptr];
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: doc/uart_tx_fifo_ctrl.md
Name: uart_tx_fifo_ctrl

Overview:
- Transmit-side buffer and launch controller that sits directly upstream of the UART transmitter.
- Accepts bytes from the host side into a circular FIFO.
- Pops one byte at a time and presents it on tx_din with a one-cycle tx_start pulse, then waits for the transmitter's tx_done_tick before launching the next byte.
- Lets the host write bursts without tracking transmitter state.

Parameters:
- DBIT, 8, data width per character; must match the transmitter's DBIT.
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W (default 16 entries).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  host write strobe, sampled on rising clk.
- wr_data  input  DBIT  byte to enqueue when wr_en is accepted.
- full  output  1  FIFO holds 2**ADDR_W entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  ADDR_W+1  current occupancy, 0..2**ADDR_W.
- ovf_tick  output  1  one-cycle pulse: a write was dropped because the FIFO was full.
- tx_busy  output  1  a byte has been launched and its tx_done_tick has not yet arrived.
- tx_start  output  1  one-cycle launch pulse to the transmitter.
- tx_din  output  DBIT  byte to transmit; valid while tx_start is high and held until the next launch.
- tx_done_tick  input  1  transmitter completion pulse (end of stop bit).

Behaviour:
- All outputs are registered.
- Reset (reset_n low, asynchronous):
  - rd_ptr = wr_ptr = 0, count = 0, empty = 1, full = 0.
  - ovf_tick = 0, tx_start = 0, tx_din = 0, tx_busy = 0, state = IDLE.
  - FIFO storage is not cleared; contents are don't-care after reset.
- Reset mid-transmission: queued bytes are discarded and no further tx_start is issued. A later stray tx_done_tick in IDLE is ignored.
- Write path:
  - A write is accepted iff wr_en = 1 and full = 0 (full as registered at that edge).
  - On acceptance: mem[wr_ptr] <= wr_data, and wr_ptr increments modulo 2**ADDR_W.
  - wr_en with full = 1: the write is dropped, pointers are unchanged, and ovf_tick = 1 for exactly one cycle.
- Pop: occurs only on the IDLE->BUSY transition. tx_din <= mem[rd_ptr], and rd_ptr increments modulo 2**ADDR_W.
- Occupancy:
  - count = count + accepted_write - pop.
  - A simultaneous accepted write and pop leaves count unchanged.
  - When the FIFO is full, a write in the same cycle as a pop is still dropped, because full is evaluated before the pop.
  - empty = (count_next == 0); full = (count_next == 2**ADDR_W). Both are registered alongside count.
- State machine (1 bit):
  - IDLE: if empty = 0, then tx_start <= 1, load tx_din, tx_busy <= 1, go to BUSY. Otherwise tx_start <= 0.
  - BUSY: tx_start <= 0. On tx_done_tick: tx_busy <= 0, go to IDLE. tx_done_tick in IDLE has no effect.
- Latency:
  - A write accepted at edge k into an empty FIFO with state = IDLE gives tx_start = 1 and tx_din = that byte after edge k+1.
  - tx_done_tick high in the cycle before edge m gives the next tx_start (if non-empty) after edge m+1.
  - This matches the transmitter: it is back in idle after edge m and samples tx_start at edge m+2.
- tx_start pulse width is always exactly one cycle. tx_din does not change while tx_busy = 1.
- Ordering is strict FIFO. Every accepted byte is launched exactly once, with no duplication or reordering across pointer wrap.

Test Plan:
- Reset, then write 0xA5 once with state IDLE -> tx_start high for exactly 1 cycle, 2 edges after the write edge; tx_din = 0xA5; tx_busy = 1; count returns to 0; empty = 1.
- Write 0x11, 0x22, 0x33 back-to-back; model the transmitter by returning tx_done_tick 20 cycles after each tx_start -> three tx_start pulses in order 0x11, 0x22, 0x33; each next tx_start occurs 2 edges after the tx_done_tick edge; never two pulses without an intervening done.
- Hold tx_done_tick low and write 17 bytes (0x00..0x10), ADDR_W = 4 -> first byte launched; full = 1, count = 16 after byte 0x10; no ovf_tick; one extra write 0x99 -> ovf_tick 1-cycle pulse, count stays 16, and 0x99 is never transmitted.
- Full FIFO, assert wr_en on the same cycle as a launch pop -> write dropped, ovf_tick = 1, count = 15 after the pop. Then write with count < 16 concurrently with a pop -> count unchanged and data ordering preserved across wr_ptr/rd_ptr wrap (run 40 bytes through).
- Deassert reset_n asynchronously while tx_busy = 1 with 5 bytes queued -> tx_start, tx_busy, and count go to 0 immediately, empty = 1; after release, a stray tx_done_tick causes no tx_start; a new write 0x5A launches normally.
